wb_stage_regfile: RTL

- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (memory load data vs ALU result) and commits it to a 32-entry architectural register file.
- Serves the two ID-stage read ports with write-before-read bypass, and exports the writeback value for EX-stage forwarding.
- Tracks the halt marker: once a halting instruction retires, the core is frozen until reset.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/regfile_2r1w.sv | 57 +++++
 rtl/wb_stage_regfile.sv | 89 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the writeback stage: data/index widths, WB control
// field positions and the halt FSM state encoding.
package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wbState_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: one synchronous write port, two read ports
// with same-cycle write bypass, and a raw debug read port.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr1,
  input  logic [ADDR_W-1:0] rdAddr2,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2,
  input  logic [ADDR_W-1:0] dbgAddr,
  output logic [DATA_W-1:0] dbgData
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wrEn && (wrAddr != '0)) begin
      regs[wrAddr] <= wrData;
    end
  end

  // Index 0 is hardwired to zero even though regs[0] is never written.
  always_comb begin
    rdData1 = regs[rdAddr1];
    if (rdAddr1 == '0) begin
      rdData1 = '0;
    end else if (wrEn && (wrAddr == rdAddr1)) begin
      rdData1 = wrData;
    end
  end

  always_comb begin
    rdData2 = regs[rdAddr2];
    if (rdAddr2 == '0) begin
      rdData2 = '0;
    end else if (wrEn && (wrAddr == rdAddr2)) begin
      rdData2 = wrData;
    end
  end

  assign dbgData = (dbgAddr == '0) ? '0 : regs[dbgAddr];

endmodule

// File: rtl/wb_stage_regfile.sv
// Writeback stage: selects load vs ALU data, commits it to the register file,
// counts committed writes and freezes the core once a halt marker retires.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_RUN    | normal retirement; HaltReg moves to ST_HALTED after commit
// ST_HALTED | writes and counting frozen, reads live; left only by reset
module wb_stage_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] MemOpReg,
  input  logic [DATA_W-1:0] ResultRTypeReg,
  input  logic [ADDR_W-1:0] WrRegReg,
  input  logic [1:0]        WBReg,
  input  logic              HaltReg,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WrBackData,
  output logic [ADDR_W-1:0] WrBackReg,
  output logic              WrBackEn,
  output logic              Halted,
  output logic [CNT_W-1:0]  WriteCount,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData
);

  wbState_e         state;
  wbState_e         stateNext;
  logic [CNT_W-1:0] writeCnt;

  assign WrBackData = WBReg[WB_MEMTOREG] ? MemOpReg : ResultRTypeReg;
  assign WrBackReg  = WrRegReg;
  // A write to index 0 is not a commit, so it must not reach the counter.
  assign WrBackEn   = (state == ST_RUN) && WBReg[WB_REGWRITE] && (WrRegReg != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_RUN:    if (HaltReg) stateNext = ST_HALTED;
      ST_HALTED: stateNext = ST_HALTED;
      default:   stateNext = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      writeCnt <= '0;
    end else if (WrBackEn) begin
      writeCnt <= writeCnt + CNT_W'(1);
    end
  end

  assign Halted     = (state == ST_HALTED);
  assign WriteCount = writeCnt;

  regfile_2r1w #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) uRegfile (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (WrBackEn),
    .wrAddr (WrRegReg),
    .wrData (WrBackData),
    .rdAddr1(ReadReg1),
    .rdAddr2(ReadReg2),
    .rdData1(ReadData1),
    .rdData2(ReadData2),
    .dbgAddr(DbgAddr),
    .dbgData(DbgData)
  );

endmodule
